// File: rtl/uart_rx_core.sv
// uart_rx_core: 8N1 UART receiver with a latched baud divisor, a break state and sticky error flags
module uart_rx_core (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  input  logic [31:0] baud_div,
  input  logic        rd_ack,
  input  logic        err_clr,
  output logic [31:0] rx_data,
  output logic        rx_valid,
  output logic        overrun,
  output logic        frame_err,
  output logic        busy
);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
  state_t      r_state;
  logic [1:0]  r_sync;
  logic [31:0] r_cnt;
  logic [31:0] r_div;
  logic [2:0]  r_idx;
  logic [7:0]  r_shift;
  logic [7:0]  r_data;
  logic        r_valid;
  logic        r_overrun;
  logic        r_ferr;
  logic        w_rx_s;
  logic        w_bit_end;
  logic        w_deliver;
  logic        w_bad_stop;
  logic [31:0] w_half;
  logic [31:0] w_div;
  assign w_rx_s     = r_sync[1];
  assign w_div      = baud_div < 32'd2 ? 32'd2 : baud_div;
  assign w_half     = r_div >> 1;
  assign w_bit_end  = r_cnt == r_div - 32'd1;
  assign w_deliver  = r_state == STOP && w_bit_end && w_rx_s;
  assign w_bad_stop = r_state == STOP && w_bit_end && !w_rx_s;
  assign rx_data    = {24'b0, r_data};
  assign rx_valid   = r_valid;
  assign overrun    = r_overrun;
  assign frame_err  = r_ferr;
  assign busy       = r_state != IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_sync    <= 2'b11;
      r_cnt     <= '0;
      r_div     <= '0;
      r_idx     <= '0;
      r_shift   <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
      r_ferr    <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], rx};
      if (w_deliver) r_data <= r_shift;
      // a read in the delivery cycle consumes the old byte, so no overrun
      r_valid   <= w_deliver ? 1'b1 : (rd_ack ? 1'b0 : r_valid);
      r_overrun <= (w_deliver && r_valid && !rd_ack) ? 1'b1 : (err_clr ? 1'b0 : r_overrun);
      r_ferr    <= w_bad_stop ? 1'b1 : (err_clr ? 1'b0 : r_ferr);
      case (r_state)
        IDLE: if (!w_rx_s) begin
          r_state <= START;
          r_cnt   <= '0;
          r_div   <= w_div;
        end
        START: if (r_cnt == w_half - 32'd1) begin
          r_state <= w_rx_s ? IDLE : DATA;
          r_cnt   <= '0;
          r_idx   <= '0;
        end else r_cnt <= r_cnt + 32'd1;
        DATA: if (w_bit_end) begin
          r_shift[r_idx] <= w_rx_s;
          r_cnt          <= '0;
          r_idx          <= r_idx + 3'd1;
          if (r_idx == 3'd7) r_state <= STOP;
        end else r_cnt <= r_cnt + 32'd1;
        STOP: if (w_bit_end) begin
          r_state <= w_rx_s ? IDLE : BREAK;
          r_cnt   <= '0;
        end else r_cnt <= r_cnt + 32'd1;
        BREAK: if (w_rx_s) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
